// File: rtl/smm_tile_accum_if.sv
// Tile accumulator bus: partial-product input stream and finished-tile output stream.
// master = producer/consumer side, slave = accumulator side.
interface smm_tile_accum_if #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 8
);
    localparam int BUSWIDTH = 4 * DATAWIDTH;

    logic                in_valid;
    logic                in_ready;
    logic [BUSWIDTH-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [BUSWIDTH-1:0] out_data;
    logic [CNTWIDTH-1:0] out_beats;
    logic                out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_ovf
    );
endinterface

// File: rtl/smm_tile_accum.sv
// smm_tile_accum: sums successive signed 2x2 partial-product tiles over K into one
// result tile and emits it on a valid/ready output with beat count and overflow flag.
// Optional feature macro SMM_ACC_SAT_EN: overflowing lanes clamp to the signed
// extremes instead of wrapping; out_ovf is reported either way.
module smm_tile_accum #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    smm_tile_accum_if.slave   bus
);
    localparam int          BUSWIDTH = 4 * DATAWIDTH;
    localparam int unsigned LANES    = 4;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BUSWIDTH-1:0]   r_acc;
    logic [CNTWIDTH-1:0]   r_beat_cnt;
    logic                  r_ovf_acc;
    logic [BUSWIDTH-1:0]   r_out_data;
    logic [CNTWIDTH-1:0]   r_out_beats;
    logic                  r_out_ovf;

    logic                  w_out_valid;
    logic                  w_hold;
    logic                  w_beat;
    logic [CNTWIDTH-1:0]   w_cnt_inc;
    logic [DATAWIDTH-1:0]  w_base [LANES];
    logic [DATAWIDTH-1:0]  w_lane [LANES];
    logic [DATAWIDTH-1:0]  w_raw  [LANES];
    logic [BUSWIDTH-1:0]   w_sum;
    logic [LANES-1:0]      w_lane_ovf;
    logic                  w_ovf;

    assign w_out_valid   = (r_state == HOLD);
    assign w_hold        = w_out_valid & ~bus.out_ready;
    assign w_beat        = bus.in_valid & ~w_hold;
    assign w_cnt_inc     = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + CNTWIDTH'(1);
    assign w_ovf         = |w_lane_ovf;

    assign bus.in_ready  = ~w_hold;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_beats = r_out_beats;
    assign bus.out_ovf   = r_out_ovf;

    // Per-lane signed add of the incoming tile onto the running sum, with overflow detect.
    always_comb begin
        w_sum      = '0;
        w_lane_ovf = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_base[i] = (r_beat_cnt == '0) ? '0 : r_acc[i*DATAWIDTH +: DATAWIDTH];
            w_lane[i] = bus.in_data[i*DATAWIDTH +: DATAWIDTH];
            w_raw[i]  = w_base[i] + w_lane[i];
            w_lane_ovf[i] = (w_base[i][DATAWIDTH-1] == w_lane[i][DATAWIDTH-1]) &&
                            (w_raw[i][DATAWIDTH-1] != w_base[i][DATAWIDTH-1]);
`ifdef SMM_ACC_SAT_EN
            if (w_lane_ovf[i]) begin
                w_sum[i*DATAWIDTH +: DATAWIDTH] = w_base[i][DATAWIDTH-1] ?
                    {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
            end else begin
                w_sum[i*DATAWIDTH +: DATAWIDTH] = w_raw[i];
            end
`else
            w_sum[i*DATAWIDTH +: DATAWIDTH] = w_raw[i];
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a last beat always (re)loads the output; otherwise a handshake drains it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM: begin
                if (w_beat && bus.in_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_beat && bus.in_last) begin
                    w_state_nxt = HOLD;
                end else if (bus.out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Accumulator and output tile registers; a last beat closes the tile and clears the sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_beat) begin
            if (bus.in_last) begin
                r_out_data  <= w_sum;
                r_out_beats <= w_cnt_inc;
                r_out_ovf   <= r_ovf_acc | w_ovf;
                r_acc       <= '0;
                r_beat_cnt  <= '0;
                r_ovf_acc   <= 1'b0;
            end else begin
                r_acc       <= w_sum;
                r_beat_cnt  <= w_cnt_inc;
                r_ovf_acc   <= r_ovf_acc | w_ovf;
            end
        end
    end
endmodule
